mem_xfer_sequencer: RTL and testbench
=====================================

// Module: mem_xfer_sequencer
// PURPOSE
//  Control-side counterpart of the ALU system datapath. Drives the Memory, ARF, DR and MUX C control inputs to move
//  1-4 bytes between byte-wide memory and the datapath in one command.
//  Load: bytes are read at AR++ and shifted into DR. Store: ALUOut bytes are selected through MUX C and written at AR++.
//  Sits between the top-level control FSM (Start/Dir/Bytes) and the datapath control pins.
// PARAMETERS
//  ARF_SEL_AR   3'b001  ARF_RegSel pattern that enables the address register (AR) only
//  ARF_FUN_INC  2'b01   ARF_FunSel code for increment
//  ADDR_OUTD    2'b10   ARF_OutDSel code routing AR to the memory Address
//  DR_FUN_LOAD  2'b01   DR_FunSel code: clear, then load I into bits [7:0]
//  DR_FUN_SHL8  2'b10   DR_FunSel code: DR <= {DR[23:0], I}
// PORTS
//  Clock        in   1  rising-edge clock
//  Reset        in   1  asynchronous, active-high reset
//  Start        in   1  command strobe; sampled in IDLE only
//  Dir          in   1  0 = load (mem->DR), 1 = store (ALUOut->mem); latched on accept
//  Bytes        in   2  transfer length minus 1 (0 -> 1 byte ... 3 -> 4 bytes); latched on accept
//  Mem_Ready    in   1  memory data-valid handshake; present only with MEM_WAIT_EN
//  Busy         out  1  high from the cycle after accept until Done is asserted
//  Done         out  1  one-cycle completion pulse
//  Mem_CS       out  1  memory chip select, active low
//  Mem_WR       out  1  memory write enable (1 = write)
//  MuxCSel      out  2  ALUOut byte select for store data
//  DR_E         out  1  DR enable
//  DR_FunSel    out  2  DR function
//  ARF_RegSel   out  3  ARF register enables
//  ARF_FunSel   out  2  ARF function
//  ARF_OutDSel  out  2  ARF OutD source; constant ADDR_OUTD
// BEHAVIOUR
//  States: IDLE, ACCESS, DONE. State, byte counter idx[1:0], dir_q and len_q[1:0] are registers.
//  All other outputs are decoded combinationally from these registers.
//  Reset (asynchronous, any state): go to IDLE with idx=0.
//   Reset output values: Mem_CS=1, Mem_WR=0, MuxCSel=0, DR_E=0, DR_FunSel=0, ARF_RegSel=0, ARF_FunSel=0,
//   Busy=0, Done=0.
//  IDLE: all control outputs inactive.
//   Start=1: latch Dir->dir_q and Bytes->len_q, set idx=0, go to ACCESS.
//  ACCESS (one byte per cycle): Mem_CS=0, Mem_WR=dir_q, Busy=1.
//   Load: DR_E=1; DR_FunSel=DR_FUN_LOAD when idx=0, DR_FUN_SHL8 otherwise.
//   Store: DR_E=0; MuxCSel = len_q - idx, so the most significant byte is written first.
//   Byte order is big-endian for both directions: the lowest address holds the MSB.
//   idx<len_q: ARF_RegSel=ARF_SEL_AR, ARF_FunSel=ARF_FUN_INC, idx++, stay in ACCESS.
//   idx==len_q: ARF_RegSel=0, so AR is left on the last byte address; go to DONE.
//  DONE: Done=1 and Busy=1 for exactly one cycle; Mem_CS=1; go to IDLE.
//  Timing: with Start accepted at edge 0, an N-byte transfer is in ACCESS for cycles 1..N and in DONE for cycle N+1.
//   The next Start is accepted no earlier than the edge that ends DONE+1, i.e. while in IDLE.
//  Start outside IDLE is ignored. Dir/Bytes changes after accept have no effect.
//  Reset during ACCESS aborts immediately. Mem_CS deasserts asynchronously. No AR increment or DR load completes
//   on a later edge.
//  Bytes=0: single ACCESS cycle with no AR increment.
// CONFIGURATION
//  MEM_WAIT_EN undefined: Mem_Ready port absent; every ACCESS cycle completes in one clock.
//  MEM_WAIT_EN defined: Mem_Ready port present. An ACCESS cycle completes only on an edge where Mem_Ready=1.
//   While Mem_Ready=0: Mem_CS stays 0, Mem_WR, MuxCSel and idx hold, DR_E=0, ARF_RegSel=0.
//   No load, shift or increment occurs during a wait.
//   N bytes with W wait cycles take N+W ACCESS cycles.
// TESTING
//  Load 4 bytes, memory AR=0x0010..0x0013 = 12 34 56 78 -> DR=0x12345678; AR=0x0013; Done pulse at cycle 5.
//  Store 2 bytes, ALUOut=0xCAFEBEEF, AR=0x0020 -> mem[0x20]=0xBE, mem[0x21]=0xEF; MuxCSel sequence 1,0; AR=0x0021.
//  Bytes=0 load from 0x0040=0xA5 -> DR=0x000000A5; ARF_RegSel=0 throughout; Done at cycle 2.
//  Start pulsed again during ACCESS of a 3-byte load -> ignored; exactly one Done pulse; AR advanced by 2 only.
//  Reset asserted mid 4-byte store after 2 bytes -> Mem_CS=1 immediately; only 2 bytes written; IDLE after release.
//  MEM_WAIT_EN defined, Mem_Ready low for 2 cycles on byte 1 of a 2-byte load -> DR correct; Done at cycle 5.

Source files
------------

// File: rtl/mem_xfer_sequencer_if.sv
// Command and control-pin bundle between the top-level control FSM, the datapath and mem_xfer_sequencer.
// The mem_ready handshake exists only when MEM_WAIT_EN is defined.
interface mem_xfer_sequencer_if;
  logic       start;
  logic       dir;
  logic [1:0] bytes;
`ifdef MEM_WAIT_EN
  logic       mem_ready;
`endif
  logic       busy;
  logic       done;
  logic       mem_cs;
  logic       mem_wr;
  logic [1:0] mux_c_sel;
  logic       dr_e;
  logic [1:0] dr_fun_sel;
  logic [2:0] arf_reg_sel;
  logic [1:0] arf_fun_sel;
  logic [1:0] arf_out_d_sel;

`ifdef MEM_WAIT_EN
  modport master (
    output start, dir, bytes, mem_ready,
    input  busy, done, mem_cs, mem_wr, mux_c_sel, dr_e, dr_fun_sel,
           arf_reg_sel, arf_fun_sel, arf_out_d_sel
  );
  modport slave (
    input  start, dir, bytes, mem_ready,
    output busy, done, mem_cs, mem_wr, mux_c_sel, dr_e, dr_fun_sel,
           arf_reg_sel, arf_fun_sel, arf_out_d_sel
  );
`else
  modport master (
    output start, dir, bytes,
    input  busy, done, mem_cs, mem_wr, mux_c_sel, dr_e, dr_fun_sel,
           arf_reg_sel, arf_fun_sel, arf_out_d_sel
  );
  modport slave (
    input  start, dir, bytes,
    output busy, done, mem_cs, mem_wr, mux_c_sel, dr_e, dr_fun_sel,
           arf_reg_sel, arf_fun_sel, arf_out_d_sel
  );
`endif
endinterface

// File: rtl/mem_xfer_sequencer.sv
// Sequences 1-4 byte big-endian load/store transfers between byte-wide memory and the ALU datapath.
// Optional feature macro MEM_WAIT_EN: adds the mem_ready handshake that stretches ACCESS cycles.
module mem_xfer_sequencer #(
  parameter logic [2:0] ARF_SEL_AR  = 3'b001,
  parameter logic [1:0] ARF_FUN_INC = 2'b01,
  parameter logic [1:0] ADDR_OUTD   = 2'b10,
  parameter logic [1:0] DR_FUN_LOAD = 2'b01,
  parameter logic [1:0] DR_FUN_SHL8 = 2'b10
) (
  input logic                  clk,
  input logic                  rst,
  mem_xfer_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  state_t     state_r;
  logic [1:0] idx_r;
  logic       dir_r;
  logic [1:0] len_r;
  logic       ready_s;

  logic       busy_s;
  logic       done_s;
  logic       mem_cs_s;
  logic       mem_wr_s;
  logic [1:0] mux_c_sel_s;
  logic       dr_e_s;
  logic [1:0] dr_fun_sel_s;
  logic [2:0] arf_reg_sel_s;
  logic [1:0] arf_fun_sel_s;

`ifdef MEM_WAIT_EN
  assign ready_s = bus.mem_ready;
`else
  assign ready_s = 1'b1;
`endif

  // Command acceptance, byte counting and state progression
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= 2'd0;
      dir_r   <= 1'b0;
      len_r   <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            dir_r   <= bus.dir;
            len_r   <= bus.bytes;
            idx_r   <= 2'd0;
            state_r <= ACCESS;
          end
        end
        ACCESS: begin
          if (ready_s) begin
            if (idx_r == len_r) begin
              state_r <= DONE;
            end else begin
              idx_r <= idx_r + 2'd1;
            end
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Control pins are decoded from registered state so reset releases the memory at once
  always_comb begin
    busy_s        = 1'b0;
    done_s        = 1'b0;
    mem_cs_s      = 1'b1;
    mem_wr_s      = 1'b0;
    mux_c_sel_s   = 2'd0;
    dr_e_s        = 1'b0;
    dr_fun_sel_s  = 2'd0;
    arf_reg_sel_s = 3'd0;
    arf_fun_sel_s = 2'd0;
    case (state_r)
      ACCESS: begin
        busy_s   = 1'b1;
        mem_cs_s = 1'b0;
        mem_wr_s = dir_r;
        // Store sends the most significant selected byte to the lowest address
        if (dir_r) begin
          mux_c_sel_s = len_r - idx_r;
        end else begin
          mux_c_sel_s = 2'd0;
        end
        if (!dir_r && ready_s) begin
          dr_e_s = 1'b1;
          if (idx_r == 2'd0) begin
            dr_fun_sel_s = DR_FUN_LOAD;
          end else begin
            dr_fun_sel_s = DR_FUN_SHL8;
          end
        end else begin
          dr_e_s       = 1'b0;
          dr_fun_sel_s = 2'd0;
        end
        // The last byte leaves AR pointing at its own address
        if (ready_s && (idx_r < len_r)) begin
          arf_reg_sel_s = ARF_SEL_AR;
          arf_fun_sel_s = ARF_FUN_INC;
        end else begin
          arf_reg_sel_s = 3'd0;
          arf_fun_sel_s = 2'd0;
        end
      end
      DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      IDLE: begin
        busy_s = 1'b0;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  assign bus.busy          = busy_s;
  assign bus.done          = done_s;
  assign bus.mem_cs        = mem_cs_s;
  assign bus.mem_wr        = mem_wr_s;
  assign bus.mux_c_sel     = mux_c_sel_s;
  assign bus.dr_e          = dr_e_s;
  assign bus.dr_fun_sel    = dr_fun_sel_s;
  assign bus.arf_reg_sel   = arf_reg_sel_s;
  assign bus.arf_fun_sel   = arf_fun_sel_s;
  assign bus.arf_out_d_sel = ADDR_OUTD;

endmodule

// File: tb/tb_mem_xfer_sequencer.sv
// Randomized self-checking bench for mem_xfer_sequencer with a small memory/AR/DR datapath model.
// Builds with or without MEM_WAIT_EN; the wait-state tests run only when it is defined.
module tb_mem_xfer_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_xfer_sequencer_if bus();
  mem_xfer_sequencer dut (.clk(clk), .rst(rst), .bus(bus.slave));

  logic [7:0]  mem [0:255];
  logic [15:0] ar;
  logic [31:0] dr;
  logic [31:0] alu_out;
  logic        ready_s = 1'b1;
  logic [1:0]  mux_q [$];
  int          n_checks = 0;
  int          n_fail = 0;

`ifdef MEM_WAIT_EN
  assign bus.mem_ready = ready_s;
`endif

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
    logic [31:0] t;
    t = w >> (8 * int'(k));
    return t[7:0];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Datapath and memory reacting to the sequencer's control pins (memory ignores reset)
  always @(posedge clk) begin
    if (!bus.mem_cs && bus.mem_wr && ready_s) mem[ar[7:0]] <= byte_of(alu_out, bus.mux_c_sel);
    if (bus.dr_e) begin
      case (bus.dr_fun_sel)
        2'b01:   dr <= {24'h000000, mem[ar[7:0]]};
        2'b10:   dr <= {dr[23:0], mem[ar[7:0]]};
        default: dr <= dr;
      endcase
    end
    if (bus.arf_reg_sel == 3'b001 && bus.arf_fun_sel == 2'b01) ar <= ar + 16'd1;
  end

  // One command: bit c of stall_mask holds mem_ready low during cycle c
  task automatic xfer(input logic d, input logic [1:0] b, input logic [31:0] stall_mask,
                      output int done_cyc, output int n_done, output int n_wait,
                      output int n_busy, output int n_inc);
    done_cyc = -1; n_done = 0; n_wait = 0; n_busy = 0; n_inc = 0;
    mux_q.delete();
    @(negedge clk);
    bus.dir = d; bus.bytes = b; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.dir = ~d; bus.bytes = ~b;
    ready_s = ~stall_mask[1];
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!bus.mem_cs) begin
        if (ready_s) mux_q.push_back(bus.mux_c_sel);
        else n_wait++;
      end
      if (bus.busy) n_busy++;
      if (bus.arf_reg_sel != 3'd0) n_inc++;
      if (bus.done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
      @(posedge clk);
      #1;
      ready_s = (c < 31) ? ~stall_mask[c + 1] : 1'b1;
    end
    ready_s = 1'b1;
  endtask

  initial begin
    logic        d;
    logic [1:0]  b;
    logic [15:0] addr;
    logic [31:0] alu, exp_dr, dr0, mask;
    logic [7:0]  pre [0:4];
    int          dc, nd, nw, nb, ni;

    rst = 1'b1;
    bus.start = 1'b0; bus.dir = 1'b0; bus.bytes = 2'd0;
    ar = 16'h0000; dr = 32'h0; alu_out = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_mem_cs", 32'(bus.mem_cs), 32'd1);
    check_eq("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    check_eq("rst_mux_c", 32'(bus.mux_c_sel), 32'd0);
    check_eq("rst_dr_e", 32'(bus.dr_e), 32'd0);
    check_eq("rst_dr_fun", 32'(bus.dr_fun_sel), 32'd0);
    check_eq("rst_arf_reg", 32'(bus.arf_reg_sel), 32'd0);
    check_eq("rst_arf_fun", 32'(bus.arf_fun_sel), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("out_d_sel", 32'(bus.arf_out_d_sel), 32'd2);
    rst = 1'b0;

    // 4-byte load 12 34 56 78 from 0x0010
    mem[8'h10] = 8'h12; mem[8'h11] = 8'h34; mem[8'h12] = 8'h56; mem[8'h13] = 8'h78;
    ar = 16'h0010; dr = 32'hFFFF_FFFF;
    xfer(1'b0, 2'd3, 32'd0, dc, nd, nw, nb, ni);
    check_eq("ld4_dr", dr, 32'h1234_5678);
    check_eq("ld4_ar", 32'(ar), 32'h0013);
    check_eq("ld4_done_cyc", 32'(dc), 32'd5);
    check_eq("ld4_n_done", 32'(nd), 32'd1);

    // 2-byte store of 0xCAFEBEEF at 0x0020
    ar = 16'h0020; alu_out = 32'hCAFE_BEEF;
    xfer(1'b1, 2'd1, 32'd0, dc, nd, nw, nb, ni);
    check_eq("st2_m20", 32'(mem[8'h20]), 32'hBE);
    check_eq("st2_m21", 32'(mem[8'h21]), 32'hEF);
    check_eq("st2_mux_n", 32'(mux_q.size()), 32'd2);
    if (mux_q.size() == 2) begin
      check_eq("st2_mux0", 32'(mux_q[0]), 32'd1);
      check_eq("st2_mux1", 32'(mux_q[1]), 32'd0);
    end
    check_eq("st2_ar", 32'(ar), 32'h0021);

    // Single byte load: no AR increment at all
    mem[8'h40] = 8'hA5; ar = 16'h0040; dr = 32'hDEAD_BEEF;
    xfer(1'b0, 2'd0, 32'd0, dc, nd, nw, nb, ni);
    check_eq("ld1_dr", dr, 32'h0000_00A5);
    check_eq("ld1_incs", 32'(ni), 32'd0);
    check_eq("ld1_ar", 32'(ar), 32'h0040);
    check_eq("ld1_done_cyc", 32'(dc), 32'd2);

    // Start re-pulsed during ACCESS of a 3-byte load must be ignored
    mem[8'h50] = 8'h01; mem[8'h51] = 8'h02; mem[8'h52] = 8'h03; mem[8'h53] = 8'h04;
    ar = 16'h0050; nd = 0;
    @(negedge clk);
    bus.dir = 1'b0; bus.bytes = 2'd2; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.done) nd++;
      bus.start = (c == 1 || c == 2);
    end
    bus.start = 1'b0;
    check_eq("restart_n_done", 32'(nd), 32'd1);
    check_eq("restart_ar", 32'(ar), 32'h0052);
    check_eq("restart_dr", dr, 32'h0001_0203);

    // Reset after two bytes of a 4-byte store aborts at once
    for (int i = 0; i < 4; i++) mem[8'h30 + i] = 8'h5A;
    ar = 16'h0030; alu_out = 32'h1122_3344;
    @(negedge clk);
    bus.dir = 1'b1; bus.bytes = 2'd3; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("abort_mem_cs", 32'(bus.mem_cs), 32'd1);
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_m30", 32'(mem[8'h30]), 32'h11);
    check_eq("abort_m31", 32'(mem[8'h31]), 32'h22);
    check_eq("abort_m32", 32'(mem[8'h32]), 32'h5A);
    check_eq("abort_m33", 32'(mem[8'h33]), 32'h5A);
    check_eq("abort_ar", 32'(ar), 32'h0032);
    check_eq("abort_idle", {30'd0, bus.busy, bus.mem_cs}, 32'd1);

`ifdef MEM_WAIT_EN
    // Two wait cycles on the second byte of a 2-byte load
    mem[8'h60] = 8'hC3; mem[8'h61] = 8'h3C; ar = 16'h0060;
    xfer(1'b0, 2'd1, 32'h0000_000C, dc, nd, nw, nb, ni);
    check_eq("wait_dr", dr, 32'h0000_C33C);
    check_eq("wait_done_cyc", 32'(dc), 32'd5);
    check_eq("wait_n_wait", 32'(nw), 32'd2);
    check_eq("wait_ar", 32'(ar), 32'h0061);
`endif

    // Randomized transfers against arithmetic expectations
    for (int t = 0; t < 24; t++) begin
      d = 1'($urandom_range(1));
      b = 2'($urandom_range(3));
      addr = 16'($urandom_range(16, 240));
      alu = $urandom;
      mask = 32'd0;
`ifdef MEM_WAIT_EN
      mask = $urandom & 32'h0000_7FFE;
`endif
      exp_dr = 32'd0;
      for (int i = 0; i < 5; i++) begin
        mem[addr[7:0] + 8'(i)] = 8'($urandom);
        pre[i] = mem[addr[7:0] + 8'(i)];
      end
      for (int i = 0; i <= int'(b); i++) exp_dr = exp_dr * 32'd256 + 32'(pre[i]);
      ar = addr; dr = $urandom; dr0 = dr; alu_out = alu;
      xfer(d, b, mask, dc, nd, nw, nb, ni);
      check_eq("rnd_done_cyc", 32'(dc), 32'(int'(b) + 2 + nw));
      check_eq("rnd_n_done", 32'(nd), 32'd1);
      check_eq("rnd_busy_cycles", 32'(nb), 32'(int'(b) + 2 + nw));
      check_eq("rnd_incs", 32'(ni), 32'(b));
      check_eq("rnd_ar", 32'(ar), 32'(addr + 16'(b)));
      if (!d) begin
        check_eq("rnd_ld_dr", dr, exp_dr);
      end else begin
        check_eq("rnd_st_dr", dr, dr0);
        for (int i = 0; i < 5; i++)
          check_eq("rnd_st_mem", 32'(mem[addr[7:0] + 8'(i)]),
                   (i <= int'(b)) ? 32'(byte_of(alu, 2'(int'(b) - i))) : 32'(pre[i]));
        check_eq("rnd_st_mux_n", 32'(mux_q.size()), 32'(int'(b) + 1));
        for (int i = 0; i < mux_q.size() && i <= int'(b); i++)
          check_eq("rnd_st_mux", 32'(mux_q[i]), 32'(int'(b) - i));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
